mskaes_128bits_ks_sequencer: RTL and testbench
==============================================

# mskaes_128bits_ks_sequencer

Control and state stage directly upstream of the masked AES-128 key-schedule round. It loads a d-share 128-bit key and holds the current round key in a share register. It drives that register into the key-schedule round (latency LATENCY) and supplies the masked RCON at the right cycle. It writes each round result back and presents round keys 0..10 to the datapath with a valid strobe, for a 10-round encryption with a fixed per-round cadence.

## Interface
- d, 2, number of shares (masking order d-1)
- LATENCY, 4, pipeline latency of the key-schedule round in cycles (≥1)

- clk  in  1  clock
- rst  in  1  reset; one clock; synchronous, active-high
- start  in  1  begin a schedule; sampled only in IDLE
- sh_key_in  in  128*d  shared cipher key; sampled on the accepted start edge
- sh_key_to_round  out  128*d  key-register contents, to the round's sh_key_in
- sh_key_from_round  in  128*d  round output (sh_key_out of the round)
- sh_RCON_out  out  8*d  masked RCON, to the round's sh_RCON_in
- sh_round_key  out  128*d  current round key (equals key register)
- round_key_valid  out  1  one-cycle strobe: sh_round_key holds key round_idx
- round_idx  out  4  index 0..10 of the key being presented
- busy  out  1  schedule in progress
- done  out  1  one-cycle strobe coincident with round-10 valid

## Operation
- Share layout is the codebase standard (share s of bit b at b*d+s). RCON is public: share 0 = RCON byte, shares 1..d-1 = 0.
- States:
  - IDLE: busy=0. start=1 → LOAD; key register ← sh_key_in.
  - LOAD: single cycle. round_key_valid=1, round_idx=0, cnt←0 → RUN.
  - RUN: key register held constant; cnt counts 0..LATENCY.
    - cnt<LATENCY: cnt++.
    - cnt==LATENCY: sh_RCON_out = RCON[round_idx]; key register ← sh_key_from_round; round_idx++; cnt←0.
    - Cycle after each capture: round_key_valid=1 (combinational on a registered flag).
    - Capture of round 10 → DONE.
  - DONE: single cycle. round_key_valid=1, round_idx=10, done=1 → IDLE.
- RCON sequence for round_idx 0..9: 01,02,04,08,10,20,40,80,1B,36. Generated by xtime on a byte register reset to 01, not a ROM.
- sh_RCON_out is all-zero outside cnt==LATENCY.
- start while busy is ignored. sh_key_from_round is ignored outside cnt==LATENCY.
- No share recombination anywhere. Key-register shares are stored and forwarded independently.

## Timing
- Reset values: key register 0 (all shares), sh_key_to_round=0, sh_round_key=0, sh_RCON_out=0, round_key_valid=0, round_idx=0, done=0, busy=0, cnt=0, RCON register=01, state IDLE.
- rst during any state aborts the schedule: all of the above next cycle, no done pulse. rst has priority over start in the same cycle.
- Start accepted at edge E0 → round key 0 valid in cycle 1. Round key r valid in cycle 1+r*(LATENCY+1). LATENCY=4 → round key 10 and done in cycle 51.
- busy rises in cycle 1 and falls in the cycle after done.
- A new start is accepted no earlier than the cycle after done.
- Round period is LATENCY+1: the round's output is stable from LATENCY cycles after its input changes, and it is sampled then.

## Structure
- Shared package/header: NUM_ROUNDS=10, the RCON initial value 8'h01, the xtime reduction constant 8'h1B, and state encodings.
- One sub-module: mskaes_rcon_gen (8-bit RCON register with reset/advance, xtime step, d-share expansion of the public byte).
- Key register uses MSKreg with count=128 and a load/hold/capture mux in front.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, random share 0, share 1 = key^share0, round instantiated with LATENCY=4. Recombined round key 10 must equal d014f9a8c9ee2589e13f0cc8b6630ca6, in cycle 51 with done=1.
- Same run: recombined sh_RCON_out at each cnt==LATENCY must equal 01..36 in order. It must be zero in all other cycles. Share 1 of sh_RCON_out must always be 0.
- start asserted again in cycle 20 with a different key → ignored; the round-10 result is unchanged.
- rst asserted in cycle 30 → next cycle busy=0, round_idx=0, all key shares 0, no done. A fresh start then completes correctly.
- Two back-to-back schedules with start held high continuously → the second starts the cycle after the first done. Both key-10 values are correct.
- LATENCY=1 and LATENCY=6 builds → round key 10 in cycles 21 and 71 respectively, with correct values.

Source files
------------

// File: rtl/mskaes_128bits_ks_sequencer_pkg.sv
// mskaes_128bits_ks_sequencer_pkg: shared constants, state encoding and xtime helper for the key-schedule sequencer
package mskaes_128bits_ks_sequencer_pkg;
  localparam int NUM_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/MSKreg.sv
// MSKreg: register bank for count shared bits; every share is stored independently
module MSKreg #(
  parameter int d = 2,
  parameter int count = 1
) (
  input  logic               clk,
  input  logic [count*d-1:0] in_i,
  output logic [count*d-1:0] out_o
);
  always_ff @(posedge clk) out_o <= in_i;
endmodule

// File: rtl/mskaes_rcon_gen.sv
// mskaes_rcon_gen: public RCON byte register advanced by xtime, expanded to d shares (share 0 carries the byte)
module mskaes_rcon_gen
  import mskaes_128bits_ks_sequencer_pkg::*;
#(
  parameter int d = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init_i,
  input  logic           adv_i,
  input  logic           en_i,
  output logic [8*d-1:0] sh_rcon_o
);
  logic [7:0] rcon_q, rcon_d;
  always_comb rcon_d = init_i ? RCON_INIT : adv_i ? xtime(rcon_q) : rcon_q;
  always_ff @(posedge clk) begin
    if (rst) rcon_q <= RCON_INIT;
    else rcon_q <= rcon_d;
  end
  always_comb begin
    sh_rcon_o = '0;
    for (int b = 0; b < 8; b++) sh_rcon_o[b*d] = en_i & rcon_q[b];
  end
endmodule

// File: rtl/mskaes_128bits_ks_sequencer.sv
// mskaes_128bits_ks_sequencer: holds the shared round key, drives the key-schedule round and presents round keys 0..10
module mskaes_128bits_ks_sequencer
  import mskaes_128bits_ks_sequencer_pkg::*;
#(
  parameter int d = 2,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [128*d-1:0] sh_key_in,
  output logic [128*d-1:0] sh_key_to_round,
  input  logic [128*d-1:0] sh_key_from_round,
  output logic [8*d-1:0]   sh_RCON_out,
  output logic [128*d-1:0] sh_round_key,
  output logic             round_key_valid,
  output logic [3:0]       round_idx,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] round_q, round_d;
  logic cap_q;
  logic [128*d-1:0] key_q, key_d;
  logic accept, capture, counting;
  // LOAD doubles as the cnt==0 cycle of round 0 so every round period is LATENCY+1
  always_comb begin
    accept = (state_q == S_IDLE) && start;
    capture = (state_q == S_RUN) && (cnt_q == CNT_LAST);
    counting = (state_q == S_LOAD) || (state_q == S_RUN);
    state_d = state_q == S_IDLE ? (start ? S_LOAD : S_IDLE) :
              state_q == S_LOAD ? S_RUN :
              state_q == S_RUN  ? ((capture && round_q == LAST_ROUND - 4'd1) ? S_DONE : S_RUN) :
              S_IDLE;
    cnt_d = (counting && !capture) ? cnt_q + CW'(1) : '0;
    round_d = capture ? round_q + 4'd1 : (state_q == S_RUN || state_q == S_DONE) ? round_q : 4'd0;
    if (state_q == S_DONE) round_d = 4'd0;
    key_d = rst ? '0 : accept ? sh_key_in : capture ? sh_key_from_round : key_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      round_q <= 4'd0;
      cap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      round_q <= round_d;
      cap_q <= capture;
    end
  end
  MSKreg #(.d(d), .count(128)) u_key_reg (
    .clk  (clk),
    .in_i (key_d),
    .out_o(key_q)
  );
  mskaes_rcon_gen #(.d(d)) u_rcon (
    .clk      (clk),
    .rst      (rst),
    .init_i   (accept),
    .adv_i    (capture),
    .en_i     (capture),
    .sh_rcon_o(sh_RCON_out)
  );
  assign sh_key_to_round = key_q;
  assign sh_round_key = key_q;
  assign round_key_valid = (state_q == S_LOAD) || cap_q;
  assign round_idx = round_q;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
endmodule

// File: tb/tb_mskaes_128bits_ks_sequencer.sv
// tb_mskaes_128bits_ks_sequencer: directed runs of the sequencer at LATENCY 4/1/6 against a reference masked round
module tb_mskaes_128bits_ks_sequencer;
  localparam int NI = 3;
  localparam logic [7:0] RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [255:0] sh_key_in = '0;
  logic [255:0] rk_v [NI];
  logic [15:0] rc_v [NI];
  logic [3:0] idx_v [NI];
  logic vld_v [NI];
  logic done_v [NI];
  logic busy_v [NI];
  logic [127:0] k10_obs = '0;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  function automatic int lat_of(input int g);
    return g == 0 ? 4 : g == 1 ? 1 : 6;
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, b;
    r = 8'h01; b = a;
    for (int e = 254; e > 0; e = e >> 1) begin
      if ((e & 1) != 0) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] recomb128(input logic [255:0] x);
    logic [127:0] r;
    for (int b = 0; b < 128; b++) r[b] = x[2*b] ^ x[2*b+1];
    return r;
  endfunction
  function automatic logic [7:0] recomb8(input logic [15:0] x);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = x[2*b] ^ x[2*b+1];
    return r;
  endfunction
  function automatic logic [7:0] share1_8(input logic [15:0] x);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = x[2*b+1];
    return r;
  endfunction
  function automatic logic [255:0] mkshare(input logic [127:0] k, input logic [127:0] m);
    logic [255:0] s;
    for (int b = 0; b < 128; b++) begin
      s[2*b] = m[b];
      s[2*b+1] = k[b] ^ m[b];
    end
    return s;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // reference round: key path delayed LATENCY cycles, RCON folded in combinationally, output remasked
  for (genvar g = 0; g < NI; g++) begin : g_lat
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : 6;
    logic [255:0] to_r, from_r;
    logic [127:0] dl [L];
    logic [127:0] mask_q = '0;
    always @(posedge clk) begin
      dl[0] <= recomb128(to_r);
      for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
      mask_q <= rnd128();
    end
    always_comb from_r = mkshare(expand(dl[L-1], recomb8(rc_v[g])), mask_q);
    mskaes_128bits_ks_sequencer #(.d(2), .LATENCY(L)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .sh_key_in        (sh_key_in),
      .sh_key_to_round  (to_r),
      .sh_key_from_round(from_r),
      .sh_RCON_out      (rc_v[g]),
      .sh_round_key     (rk_v[g]),
      .round_key_valid  (vld_v[g]),
      .round_idx        (idx_v[g]),
      .busy             (busy_v[g]),
      .done             (done_v[g])
    );
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 256'(busy_v[0]), '0);
    chk({tag, "_done"}, 256'(done_v[0]), '0);
    chk({tag, "_valid"}, 256'(vld_v[0]), '0);
    chk({tag, "_idx"}, 256'(idx_v[0]), '0);
    chk({tag, "_key"}, rk_v[0], '0);
    chk({tag, "_rcon"}, 256'(rc_v[0]), '0);
  endtask
  // checks cycles 1..kmax after the accepted start edge; optional ignored start pulse or abort
  task automatic sched(input logic [127:0] key, input int kmax, input int pulse_at,
                       input logic [127:0] alt, input int rst_at, input bit all);
    logic [127:0] ek [11];
    int p, eb;
    bit ev;
    logic [7:0] erc;
    ek[0] = key;
    for (int r = 0; r < 10; r++) ek[r+1] = expand(ek[r], RC[r]);
    for (int k = 1; k <= kmax; k++) begin
      for (int g = 0; g < NI; g++) begin
        p = lat_of(g) + 1;
        eb = 1 + 10 * p;
        if (g == 0) begin
          ev = (k <= eb) && ((k - 1) % p == 0);
          erc = ((k % p == 0) && (k < eb)) ? RC[k/p-1] : 8'h00;
          chk($sformatf("c%0d_valid", k), 256'(vld_v[0]), 256'(ev));
          chk($sformatf("c%0d_done", k), 256'(done_v[0]), 256'(k == eb));
          chk($sformatf("c%0d_busy", k), 256'(busy_v[0]), 256'(k <= eb));
          chk($sformatf("c%0d_rcon", k), 256'(recomb8(rc_v[0])), 256'(erc));
          chk($sformatf("c%0d_rcon_sh1", k), 256'(share1_8(rc_v[0])), '0);
          if (ev) begin
            chk($sformatf("c%0d_idx", k), 256'(idx_v[0]), 256'((k - 1) / p));
            chk($sformatf("c%0d_rkey", k), 256'(recomb128(rk_v[0])), 256'(ek[(k-1)/p]));
          end
          if (k == eb) k10_obs = recomb128(rk_v[0]);
        end else if (all) begin
          if (k == eb - 1) chk($sformatf("L%0d_c%0d_done", p - 1, k), 256'(done_v[g]), '0);
          if (k == eb) begin
            chk($sformatf("L%0d_c%0d_done", p - 1, k), 256'(done_v[g]), 256'(1));
            chk($sformatf("L%0d_c%0d_k10", p - 1, k), 256'(recomb128(rk_v[g])), 256'(ek[10]));
          end
        end
      end
      if (k == kmax) return;
      if (k == pulse_at) begin
        start = 1'b1;
        sh_key_in = mkshare(alt, rnd128());
        step();
        start = 1'b0;
      end else if (k == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle($sformatf("abort_c%0d", k + 1));
        return;
      end else step();
    end
  endtask
  initial begin
    repeat (3) step();
    chk_idle("reset");
    rst = 1'b0;
    step();
    chk_idle("idle");
    sh_key_in = mkshare(FIPS_KEY, rnd128());
    start = 1'b1;
    step();
    start = 1'b0;
    sched(FIPS_KEY, 72, 20, 128'h000102030405060708090a0b0c0d0e0f, 0, 1'b1);
    chk("fips_k10", 256'(k10_obs), 256'(FIPS_K10));
    sh_key_in = mkshare(128'h00112233445566778899aabbccddeeff, rnd128());
    start = 1'b1;
    step();
    start = 1'b0;
    sched(128'h00112233445566778899aabbccddeeff, 40, 0, '0, 30, 1'b0);
    sh_key_in = mkshare(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, rnd128());
    start = 1'b1;
    step();
    start = 1'b0;
    sched(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 72, 0, '0, 0, 1'b1);
    sh_key_in = mkshare(128'hffffffffffffffffffffffffffffffff, rnd128());
    start = 1'b1;
    step();
    sh_key_in = mkshare(128'h80000000000000000000000000000001, rnd128());
    sched(128'hffffffffffffffffffffffffffffffff, 52, 0, '0, 0, 1'b0);
    step();
    sched(128'h80000000000000000000000000000001, 52, 0, '0, 0, 1'b0);
    start = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
